// File: rtl/mvau_inp_buf_ctrl.sv
// ---------------------------------------------------------------------------
// mvau_inp_buf_ctrl
//
// Sequencer for the MVAU stream input buffer. Each input vector of SF words
// is accepted from upstream and written into the buffer. In the same cycle it
// is passed through to the PE array. The stored vector is then re-read once
// for every remaining neuron fold (NF-1 passes). Every word delivered to the
// PE array carries accumulator clear/last flags.
//
// Parameters
//   SF        synapse fold: words per input vector (>= 1)
//   NF        neuron fold: passes over each vector (>= 1)
//   BUF_ADDR  buffer address width, max(1, clog2(SF))
//
// Ports
//   clk          clock
//   rst_n        synchronous reset, active HIGH (1 = reset)
//   in_v         upstream word valid
//   in_rdy       upstream ready; a word transfers when in_v & in_rdy
//   out_rdy      PE array enable; a word is issued only while this is 1
//   wr_en        buffer write enable (write-through pass)
//   rd_en        buffer read enable (re-read passes)
//   addr         buffer address, equal to the synapse-fold counter
//   out_v        buffer output word valid (one cycle after the issue)
//   out_sf_clr   with out_v: first word of a dot product
//   out_sf_last  with out_v: last word of a dot product
// ---------------------------------------------------------------------------
module mvau_inp_buf_ctrl #(
  parameter int SF       = 4,
  parameter int NF       = 3,
  parameter int BUF_ADDR = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_v,
  output logic                in_rdy,
  input  logic                out_rdy,
  output logic                wr_en,
  output logic                rd_en,
  output logic [BUF_ADDR-1:0] addr,
  output logic                out_v,
  output logic                out_sf_clr,
  output logic                out_sf_last
);

  localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;
  localparam logic [BUF_ADDR-1:0] SF_LAST = BUF_ADDR'(SF - 1);
  localparam logic [NF_W-1:0]     NF_LAST = NF_W'(NF - 1);

  // WRITE while nf_cnt is 0, READ otherwise. Kept as its own register so the
  // combinational controls decode one bit instead of comparing nf_cnt.
  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_READ  = 1'b1
  } state_t;

  state_t              state_reg;
  logic [BUF_ADDR-1:0] sf_cnt_reg;
  logic [NF_W-1:0]     nf_cnt_reg;
  logic                out_v_reg;
  logic                out_sf_clr_reg;
  logic                out_sf_last_reg;

  logic                issue;
  logic                sf_at_last;
  logic                nf_at_last;

  assign sf_at_last = (sf_cnt_reg == SF_LAST);
  assign nf_at_last = (nf_cnt_reg == NF_LAST);

  // Buffer controls act in the cycle of the issue, so they are combinational.
  // in_rdy does not look at in_v. While reset is asserted, all controls are
  // forced idle.
  always_comb begin
    in_rdy = 1'b0;
    issue  = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    addr   = '0;
    if (!rst_n) begin
      in_rdy = (state_reg == ST_WRITE) && out_rdy;
      issue  = out_rdy && ((state_reg == ST_READ) || in_v);
      wr_en  = issue && (state_reg == ST_WRITE);
      rd_en  = issue && (state_reg == ST_READ);
      // addr follows sf_cnt even when there is no issue. This keeps the
      // buffer's registered read data undisturbed.
      addr   = sf_cnt_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg       <= ST_WRITE;
      sf_cnt_reg      <= '0;
      nf_cnt_reg      <= '0;
      out_v_reg       <= 1'b0;
      out_sf_clr_reg  <= 1'b0;
      out_sf_last_reg <= 1'b0;
    end else begin
      // Flags line up with the buffer's registered output, one cycle after
      // the issue.
      out_v_reg       <= issue;
      out_sf_clr_reg  <= issue && (sf_cnt_reg == '0);
      out_sf_last_reg <= issue && sf_at_last;
      if (issue) begin
        if (sf_at_last) begin
          sf_cnt_reg <= '0;
          if (nf_at_last) begin
            nf_cnt_reg <= '0;
            state_reg  <= ST_WRITE;
          end else begin
            nf_cnt_reg <= nf_cnt_reg + 1'b1;
            state_reg  <= ST_READ;
          end
        end else begin
          sf_cnt_reg <= sf_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign out_v       = out_v_reg;
  assign out_sf_clr  = out_sf_clr_reg;
  assign out_sf_last = out_sf_last_reg;

endmodule
